// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port controller: merges pipeline writeback with buffered long-latency results
// and keeps the per-register busy scoreboard. Define LL_BYPASS_EN for zero-latency writes through an empty FIFO.
module regfile_wb_ctrl #(
  parameter int unsigned REG_NUM    = 32,
  parameter int unsigned RF_AW      = 5,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LQ_DEPTH   = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [RF_AW-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_hold,
  input  logic              ll_issue,
  input  logic [RF_AW-1:0]  ll_issue_rd,
  input  logic              ll_valid,
  output logic              ll_ready,
  input  logic [RF_AW-1:0]  ll_rd,
  input  logic [DATA_W-1:0] ll_data,
  input  logic [RF_AW-1:0]  id_rs1,
  input  logic [RF_AW-1:0]  id_rs2,
  input  logic [RF_AW-1:0]  id_rd,
  output logic              id_stall,
  output logic              rf_wen,
  output logic [RF_AW-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_din
);

  localparam int unsigned LQ_AW = $clog2(LQ_DEPTH);
  localparam int unsigned LQ_CW = $clog2(LQ_DEPTH + 1);
  localparam int unsigned SV_W  = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [RF_AW-1:0]  rd;
    logic [DATA_W-1:0] data;
  } lq_entry_t;

  lq_entry_t          lq_mem [LQ_DEPTH];
  lq_entry_t          lq_head;
  logic [LQ_AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LQ_CW-1:0]   lq_cnt_q, lq_cnt_nxt;
  logic [REG_NUM-1:0] busy_q, busy_nxt;
  logic [SV_W-1:0]    starve_q, starve_nxt;
  logic               lq_empty, lq_full, lq_push, lq_pop, ll_byp;
  logic               clr_en;
  logic [RF_AW-1:0]   clr_rd;

  assign lq_empty = (lq_cnt_q == '0);
  assign lq_full  = (lq_cnt_q == LQ_CW'(LQ_DEPTH));
  assign lq_head  = lq_mem[rd_ptr_q];
  assign ll_ready = rst & ~lq_full;
  assign lq_pop   = rst & ~wb_valid & ~lq_empty;

`ifdef LL_BYPASS_EN
  assign ll_byp = rst & ~wb_valid & lq_empty & ll_valid;
`else
  assign ll_byp = 1'b0;
`endif

  assign lq_push    = ll_valid & ll_ready & ~ll_byp;
  assign lq_cnt_nxt = lq_cnt_q + LQ_CW'(lq_push) - LQ_CW'(lq_pop);

  // Write-port arbitration: pipeline writeback first, then FIFO head, then bypass; x0 never written.
  always_comb begin
    rf_wen   = 1'b0;
    rf_waddr = '0;
    rf_din   = '0;
    clr_en   = 1'b0;
    clr_rd   = '0;
    if (rst && wb_valid) begin
      if (wb_rd != '0) begin
        rf_wen   = 1'b1;
        rf_waddr = wb_rd;
        rf_din   = wb_data;
      end
    end else if (lq_pop) begin
      clr_en = 1'b1;
      clr_rd = lq_head.rd;
      if (lq_head.rd != '0) begin
        rf_wen   = 1'b1;
        rf_waddr = lq_head.rd;
        rf_din   = lq_head.data;
      end
    end else if (ll_byp) begin
      clr_en = 1'b1;
      clr_rd = ll_rd;
      if (ll_rd != '0) begin
        rf_wen   = 1'b1;
        rf_waddr = ll_rd;
        rf_din   = ll_data;
      end
    end
  end

  // Scoreboard update; a new issue overrides a same-cycle clear of the same register.
  always_comb begin
    busy_nxt = busy_q;
    if (clr_en) busy_nxt[clr_rd] = 1'b0;
    if (ll_issue) busy_nxt[ll_issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Count consecutive lost arbitrations of a non-empty FIFO, saturating at the hold threshold.
  always_comb begin
    starve_nxt = starve_q;
    if (lq_empty || lq_pop) begin
      starve_nxt = '0;
    end else if (wb_valid && (starve_q < SV_W'(STARVE_MAX))) begin
      starve_nxt = starve_q + SV_W'(1);
    end
  end

  assign id_stall = busy_q[id_rs1] | busy_q[id_rs2] | busy_q[id_rd];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lq_cnt_q <= '0;
      busy_q   <= '0;
      starve_q <= '0;
      wb_hold  <= 1'b0;
    end else begin
      if (lq_push) wr_ptr_q <= wr_ptr_q + LQ_AW'(1);
      if (lq_pop)  rd_ptr_q <= rd_ptr_q + LQ_AW'(1);
      lq_cnt_q <= lq_cnt_nxt;
      busy_q   <= busy_nxt;
      starve_q <= starve_nxt;
      wb_hold  <= (starve_nxt >= SV_W'(STARVE_MAX));
    end
  end

  // Result storage needs no reset; occupancy is tracked by the counter.
  always_ff @(posedge clk) begin
    if (lq_push) lq_mem[wr_ptr_q] <= '{rd: ll_rd, data: ll_data};
  end

  // Issuing to a register that is still busy would break the WAW guarantee.
  a_issue_not_busy: assert property (@(posedge clk) disable iff (!rst)
    !(ll_issue && busy_q[ll_issue_rd]));

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Randomized and directed bench for regfile_wb_ctrl against a queue-based reference model.
// Define LL_BYPASS_EN consistently for bench and design to exercise the bypass build.
module tb_regfile_wb_ctrl;

  localparam int unsigned LQ_DEPTH   = 2;
  localparam int unsigned STARVE_MAX = 4;
`ifdef LL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, wb_hold, ll_issue, ll_valid, ll_ready, id_stall, rf_wen;
  logic [4:0]  wb_rd, ll_issue_rd, ll_rd, id_rs1, id_rs2, id_rd, rf_waddr;
  logic [31:0] wb_data, ll_data, rf_din;

  regfile_wb_ctrl #(
    .REG_NUM(32), .RF_AW(5), .DATA_W(32), .LQ_DEPTH(LQ_DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_hold(wb_hold),
    .ll_issue(ll_issue), .ll_issue_rd(ll_issue_rd),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_data(ll_data),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_stall(id_stall),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_din(rf_din)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t       q_m[$];
  bit         busy_m [32];
  int         losses;
  bit         hold_m;
  bit         acc;
  int         n_chk, n_pass;
  logic [4:0] outs[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    q_m.delete();
    outs.delete();
    foreach (busy_m[i]) busy_m[i] = 1'b0;
    losses = 0;
    hold_m = 1'b0;
  endtask

  task automatic drive(input bit wbv, input logic [4:0] wbrd, input logic [31:0] wbd,
                       input bit iss, input logic [4:0] isrd,
                       input bit llv, input logic [4:0] llrd, input logic [31:0] lld,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] idrd);
    wb_valid = wbv && !hold_m;
    wb_rd = wbrd; wb_data = wbd;
    ll_issue = iss; ll_issue_rd = isrd;
    ll_valid = llv; ll_rd = llrd; ll_data = lld;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = idrd;
  endtask

  task automatic idle(input logic [4:0] rs);
    drive(0, 0, 0, 0, 0, 0, 0, 0, rs, 0, 0);
  endtask

  // Called at posedge+1 with inputs applied: checks outputs at the falling edge, then advances the model.
  task automatic cycle();
    bit          exp_ready, exp_wen, popped, byp;
    logic [4:0]  ea;
    logic [31:0] ed;
    ent_t        e;
    exp_ready = (q_m.size() < LQ_DEPTH);
    popped    = !wb_valid && (q_m.size() != 0);
    byp       = BYP && !wb_valid && (q_m.size() == 0) && ll_valid;
    exp_wen = 0; ea = 0; ed = 0;
    if (wb_valid) begin
      if (wb_rd != 0) begin exp_wen = 1; ea = wb_rd; ed = wb_data; end
    end else if (popped) begin
      if (q_m[0].rd != 0) begin exp_wen = 1; ea = q_m[0].rd; ed = q_m[0].data; end
    end else if (byp) begin
      if (ll_rd != 0) begin exp_wen = 1; ea = ll_rd; ed = ll_data; end
    end
    #4;
    chk("rf_wen", 64'(rf_wen), 64'(exp_wen));
    chk("rf_waddr", 64'(rf_waddr), 64'(ea));
    chk("rf_din", 64'(rf_din), 64'(ed));
    chk("ll_ready", 64'(ll_ready), 64'(exp_ready));
    chk("id_stall", 64'(id_stall), 64'(busy_m[id_rs1] | busy_m[id_rs2] | busy_m[id_rd]));
    chk("wb_hold", 64'(wb_hold), 64'(hold_m));
    @(posedge clk);
    acc = ll_valid && exp_ready;
    if (popped || q_m.size() == 0) losses = 0;
    else if (wb_valid && losses < STARVE_MAX) losses++;
    hold_m = (losses >= STARVE_MAX);
    if (popped) begin
      e = q_m.pop_front();
      busy_m[e.rd] = 0;
    end else if (byp) begin
      busy_m[ll_rd] = 0;
    end
    if (acc && !byp) begin
      e.rd = ll_rd; e.data = ll_data;
      q_m.push_back(e);
    end
    if (ll_issue) busy_m[ll_issue_rd] = 1;
    busy_m[0] = 0;
    #1;
  endtask

  initial begin
    int k;
    n_chk = 0; n_pass = 0;
    model_reset();
    rst = 1'b0;
    idle(0);
    #12 rst = 1'b1;
    @(posedge clk); #1;

    // Long-latency result into an empty FIFO with the pipeline idle
    drive(0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 1, 9, 32'h55, 9, 0, 0); cycle();
    idle(9); cycle();
    idle(9); cycle();

    // Writeback and long-latency result collide
    drive(0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0); cycle();
    drive(1, 3, 32'hAA, 0, 0, 1, 5, 32'hBB, 5, 0, 0); cycle();
    idle(5); cycle();
    idle(5); cycle();

    // RAW and WAW hazards on x7
    drive(0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0); cycle();
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0); cycle(); end
    drive(0, 0, 0, 0, 0, 1, 7, 32'h77, 0, 0, 7); cycle();
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7); cycle(); end

    // x0 destinations
    drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0); cycle();
    drive(1, 0, 32'h11, 0, 0, 1, 0, 32'h22, 0, 0, 0); cycle();
    idle(0); cycle();
    idle(0); cycle();

    // Full FIFO under continuous writeback, starvation hold, then in-order drain
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 1, 5'(10 + i), 0, 0, 0, 0, 0, 0); cycle(); end
    k = 0;
    for (int i = 0; i < 14; i++) begin
      drive(i < 9, 1, 32'(i), 0, 0, k < 3, 5'(10 + k), 32'hC0 + 32'(k), 5'(10 + (i % 3)), 0, 0);
      cycle();
      if (acc && k < 3) k++;
    end

    // Asynchronous reset with two entries queued and writeback active
    drive(0, 0, 0, 1, 22, 0, 0, 0, 0, 0, 0); cycle();
    for (int i = 0; i < 2; i++) begin drive(0, 0, 0, 1, 5'(20 + i), 0, 0, 0, 0, 0, 0); cycle(); end
    for (int i = 0; i < 2; i++) begin
      drive(1, 2, 32'h33, 0, 0, 1, 5'(20 + i), 32'hD0 + 32'(i), 0, 0, 0); cycle();
    end
    drive(1, 2, 32'h44, 0, 0, 0, 0, 0, 22, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk("rst_wen", 64'(rf_wen), 64'd0);
    chk("rst_ready", 64'(ll_ready), 64'd0);
    chk("rst_stall", 64'(id_stall), 64'd0);
    chk("rst_hold", 64'(wb_hold), 64'd0);
    model_reset();
    idle(22);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    idle(22); cycle();

    // Random traffic honouring issue legality and wb_hold
    for (int i = 0; i < 500; i++) begin
      bit         wbv, iss, llv;
      logic [4:0] wbrd, isrd;
      wbv  = ($urandom % 3) != 0;
      wbrd = 5'($urandom % 32);
      if (busy_m[wbrd]) wbrd = 0;
      isrd = 5'($urandom % 32);
      iss  = (($urandom % 3) == 0) && !busy_m[isrd] && (outs.size() < 4);
      llv  = (outs.size() > 0) && (($urandom % 2) == 0);
      drive(wbv, wbrd, $urandom, iss, isrd, llv, llv ? outs[0] : 5'd0, $urandom,
            5'($urandom % 32), 5'($urandom % 32), 5'($urandom % 32));
      cycle();
      if (acc) void'(outs.pop_front());
      if (iss) outs.push_back(isrd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
